// File: rtl/fb_read_arbiter.sv
// Shared BRAM read-port arbiter: one grant per cycle, return data steered back
// to the requesting client through a READ_LATENCY-deep grant tag pipeline.
module fb_read_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 2,
    parameter int unsigned ADDR_WIDTH   = 19,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned PRIO0        = 1,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned IDW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                              clk_25mhz,
    input  logic                              resetn,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
    output logic [NUM_CLIENTS-1:0]            gnt,
    output logic [NUM_CLIENTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_en,
    input  logic [DATA_WIDTH-1:0]             mem_dout,
    input  logic                              lock_en,
    input  logic [IDW-1:0]                    lock_id,
    output logic                              starve_evt
);

    localparam int unsigned      CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [IDW-1:0]   RR_RESET = IDW'((NUM_CLIENTS > 1) ? 1 : 0);

    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         rr_next;
    logic                   rr_upd;
    logic [IDW-1:0]         sel;
    logic                   found;
    logic                   preempt;
    int unsigned            rr_cand;
    int unsigned            rr_nxt;
    logic [CNT_W-1:0]       starve_cnt [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] tag_q      [READ_LATENCY];

    // Winner selection: lock, then starvation preemption, then client 0 priority, then round-robin
    always_comb begin
        sel     = '0;
        found   = 1'b0;
        preempt = 1'b0;
        rr_upd  = 1'b0;
        rr_next = rr_ptr;
        rr_cand = 0;
        rr_nxt  = 0;
        if (resetn) begin
            if (lock_en) begin
                for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
                    if (lock_id == IDW'(k) && req[k]) begin
                        found = 1'b1;
                        sel   = IDW'(k);
                    end
                end
            end else begin
                if (STARVE_LIMIT != 0) begin
                    for (int unsigned k = 1; k < NUM_CLIENTS; k++) begin
                        if (!found && req[k] && starve_cnt[k] >= CNT_MAX) begin
                            found   = 1'b1;
                            preempt = 1'b1;
                            sel     = IDW'(k);
                        end
                    end
                end
                if (!found && PRIO0 != 0 && req[0]) begin
                    found = 1'b1;
                    sel   = '0;
                end else if (!found) begin
                    for (int unsigned off = 0; off < NUM_CLIENTS; off++) begin
                        rr_cand = (32'(rr_ptr) + off) % NUM_CLIENTS;
                        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
                            if (!found && rr_cand == k && req[k] && !(PRIO0 != 0 && k == 0)) begin
                                found  = 1'b1;
                                rr_upd = 1'b1;
                                sel    = IDW'(k);
                            end
                        end
                    end
                end
                if (preempt) begin
                    rr_upd = 1'b1;
                end
                // Pointer moves past the winner, skipping client 0 when it has its own priority lane
                rr_nxt = (32'(sel) + 32'd1) % NUM_CLIENTS;
                if (PRIO0 != 0 && rr_nxt == 0 && NUM_CLIENTS > 1) begin
                    rr_nxt = 1;
                end
                rr_next = IDW'(rr_nxt);
            end
        end
    end

    // One-hot grant and the address of the granted client
    always_comb begin
        gnt      = '0;
        mem_addr = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            if (found && sel == IDW'(k)) begin
                gnt[k]   = 1'b1;
                mem_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign mem_en     = |gnt;
    assign starve_evt = preempt;
    assign rvalid     = tag_q[READ_LATENCY-1];
    assign rdata      = mem_dout;

    // Tag pipeline, round-robin pointer and starvation counters (frozen while locked)
    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            rr_ptr <= RR_RESET;
            for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
                starve_cnt[k] <= '0;
            end
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (rr_upd) begin
                rr_ptr <= rr_next;
            end
            if (!lock_en) begin
                for (int unsigned k = 1; k < NUM_CLIENTS; k++) begin
                    if (gnt[k] || !req[k]) begin
                        starve_cnt[k] <= '0;
                    end else if (starve_cnt[k] < CNT_MAX) begin
                        starve_cnt[k] <= starve_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
